// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU (ADD/SUB/AND/OR/NOR/XOR) through one 1-bit slice, LSB first,
// with start/ack handshake, abort and reserved-opcode error pulse.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_control,
  input  logic             i_ack,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out,
  output logic             o_carryout,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_err
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_out, w_final;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_carryout, r_overflow, r_zero, r_negative, r_err;
  logic             w_accept, w_reject, w_last, w_arith, w_sub;
  logic             w_a, w_b, w_sum, w_cout, w_res;
  assign w_accept = r_state == IDLE && i_start && i_control >= 3'd2;
  assign w_reject = r_state == IDLE && i_start && i_control < 3'd2;
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  assign w_arith  = r_op == 3'd2 || r_op == 3'd3;
  assign w_sub    = r_op == 3'd3;
  // the single 1-bit slice; SUB is ADD with b inverted and carry seeded with 1
  assign w_a    = r_a[r_cnt];
  assign w_b    = r_b[r_cnt] ^ w_sub;
  assign w_sum  = w_a ^ w_b ^ r_carry;
  assign w_cout = w_arith & ((w_a & w_b) | (w_a & r_carry) | (w_b & r_carry));
  assign w_res  = w_arith ? w_sum :
                  r_op == 3'd4 ? (w_a & w_b) :
                  r_op == 3'd5 ? (w_a | w_b) :
                  r_op == 3'd6 ? ~(w_a | w_b) : (w_a ^ w_b);
  always_comb begin
    w_final        = r_out;
    w_final[r_cnt] = w_res;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_accept ? RUN : IDLE) :
             r_state == RUN  ? (i_abort ? IDLE : (w_last ? DONE : RUN)) :
                               (i_ack ? IDLE : DONE);
  always_comb begin
    o_busy      = r_state == RUN;
    o_out_valid = r_state == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_out      <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_op    <= i_control;
        r_cnt   <= '0;
        r_carry <= i_control == 3'd3;
      end else if (r_state == RUN && !i_abort) begin
        r_out   <= w_final;
        r_carry <= w_cout;
        if (!w_last) r_cnt <= r_cnt + CW'(1);
        // r_carry still holds the carry into the MSB here, so overflow is cin^cout of that slice
        if (w_last) begin
          r_carryout <= w_cout;
          r_overflow <= w_arith & (r_carry ^ w_cout);
          r_zero     <= w_final == '0;
          r_negative <= w_final[WIDTH-1];
        end
      end
    end
  end
  assign o_out      = r_out;
  assign o_carryout = r_carryout;
  assign o_overflow = r_overflow;
  assign o_zero     = r_zero;
  assign o_negative = r_negative;
  assign o_err      = r_err;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: random and directed stimulus against a cycle-level behavioural model
// (arithmetic result + latency countdown), checked every cycle on the falling clock edge.
module tb_alu_serial_ctrl;
  localparam int W = 32;
  logic         clk = 1'b0, rst_n = 1'b1;
  logic         i_start = 0, i_ack = 0, i_abort = 0;
  logic [W-1:0] i_a = 0, i_b = 0;
  logic [2:0]   i_control = 0;
  logic         o_busy, o_out_valid, o_carryout, o_overflow, o_zero, o_negative, o_err;
  logic [W-1:0] o_out;
  int           n_checks = 0, n_fail = 0;
  int           lat;
  int           m_phase = 0, m_left = 0;
  logic         m_err = 0, m_c = 0, m_v = 0;
  logic [W-1:0] m_res = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .i_control(i_control), .i_ack(i_ack), .i_abort(i_abort), .o_busy(o_busy),
    .o_out_valid(o_out_valid), .o_out(o_out), .o_carryout(o_carryout),
    .o_overflow(o_overflow), .o_zero(o_zero), .o_negative(o_negative), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic [W:0] s;
    case (op)
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        return {s[W], (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s[W-1:0]};
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        return {s[W], (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]), s[W-1:0]};
      end
      3'd4: return {2'b00, a & b};
      3'd5: return {2'b00, a | b};
      3'd6: return {2'b00, ~(a | b)};
      default: return {2'b00, a ^ b};
    endcase
  endfunction

  // model: phase 0 idle, 1 computing (counts down W edges), 2 result held
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_err   = 0;
    end else begin
      m_err = 0;
      if (m_phase == 0) begin
        if (i_start && i_control >= 2) begin
          {m_c, m_v, m_res} = calc(i_a, i_b, i_control);
          m_left  = W;
          m_phase = 1;
        end else if (i_start) m_err = 1;
      end else if (m_phase == 1) begin
        if (i_abort) m_phase = 0;
        else begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
      end else if (i_ack) m_phase = 0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("busy", o_busy, m_phase == 1);
    chk("out_valid", o_out_valid, m_phase == 2);
    chk("err", o_err, m_err);
    if (m_phase == 2) begin
      chk("out", o_out, m_res);
      chk("flags", {o_carryout, o_overflow, o_zero, o_negative}, {m_c, m_v, m_res == 0, m_res[W-1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    i_a = a; i_b = b; i_control = op; i_start = 1; i_ack = 0; i_abort = 0;
    step();
    lat = 1;
    while (!o_out_valid && lat < 40) begin
      i_start = 1'($urandom); i_a = $urandom; i_b = $urandom; i_control = 3'($urandom);
      step();
      lat++;
    end
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) begin
      i_start = 1; i_control = 3'($urandom); i_ack = 0;
      step();
    end
    i_ack = 1; i_start = 1; i_control = 3'd2;
    step();
    i_ack = 0; i_start = 0;
    step();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {o_busy, o_out_valid, o_carryout, o_overflow, o_zero, o_negative, o_err, o_out}, '0);
  endtask

  initial begin
    #2 rst_n = 0;
    #1 chk_reset_outputs("reset_initial");
    step();
    rst_n = 1;
    step();
    do_op(32'h7FFFFFFF, 32'h1, 3'd2);
    chk("latency", lat, 33);
    chk("model_add", m_res, 32'h80000000);
    chk("add_out", o_out, 32'h80000000);
    chk("add_flags", {o_carryout, o_overflow, o_zero, o_negative}, 4'b0101);
    finish_op(10);
    do_op(32'd5, 32'd5, 3'd3);
    chk("sub_eq_out", o_out, 0);
    chk("sub_eq_flags", {o_carryout, o_overflow, o_zero, o_negative}, 4'b1010);
    finish_op(0);
    do_op(32'd0, 32'd1, 3'd3);
    chk("sub_neg_out", o_out, 32'hFFFFFFFF);
    chk("sub_neg_flags", {o_carryout, o_overflow, o_zero, o_negative}, 4'b0001);
    finish_op(1);
    do_op(32'hF0F0F0F0, 32'hFFFF0000, 3'd7);
    chk("xor_out", o_out, 32'h0F0FF0F0);
    chk("xor_flags", {o_carryout, o_overflow}, 2'b00);
    finish_op(2);
    do_op(32'd0, 32'd0, 3'd6);
    chk("nor_out", o_out, 32'hFFFFFFFF);
    chk("nor_flags", {o_carryout, o_overflow}, 2'b00);
    finish_op(0);
    i_start = 1; i_control = 3'd1;
    step();
    chk("rsv_err", {o_err, o_busy}, 2'b10);
    i_start = 0;
    step();
    chk("rsv_err_clear", o_err, 0);
    do_op(32'd3, 32'd4, 3'd2);
    chk("after_rsv_out", o_out, 7);
    finish_op(0);
    i_a = 32'd9; i_b = 32'd9; i_control = 3'd2; i_start = 1;
    step();
    i_start = 0;
    repeat (9) step();
    i_abort = 1;
    step();
    i_abort = 0;
    chk("abort_idle", {o_busy, o_out_valid}, 2'b00);
    repeat (40) step();
    i_a = 32'd1; i_b = 32'd2; i_control = 3'd5; i_start = 1;
    step();
    i_start = 0;
    repeat (19) step();
    #2 rst_n = 0;
    #1 chk_reset_outputs("reset_mid_run");
    step();
    rst_n = 1;
    do_op(32'd100, 32'd58, 3'd3);
    chk("after_reset_out", o_out, 42);
    #2 rst_n = 0;
    #1 chk_reset_outputs("reset_in_done");
    step();
    rst_n = 1;
    repeat (25) begin
      do_op($urandom, $urandom, 3'($urandom_range(2, 7)));
      finish_op($urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request new operation; sampled only in IDLE.
REQ-005 A  input  WIDTH  operand A, captured on accepted start.
REQ-006 B  input  WIDTH  operand B, captured on accepted start.
REQ-007 control  input  3  op code, captured on accepted start: 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOR, 7 XOR; 0 and 1 reserved.
REQ-008 ack  input  1  consumer accepts result; sampled only in DONE.
REQ-009 abort  input  1  cancel operation in progress; sampled only in RUN.
REQ-010 busy  output  1  high in RUN.
REQ-011 out_valid  output  1  high in DONE.
REQ-012 out  output  WIDTH  result word.
REQ-013 carryout  output  1  carry out of MSB slice (ADD/SUB), else 0.
REQ-014 overflow  output  1  signed overflow (ADD/SUB), else 0.
REQ-015 zero  output  1  out == 0.
REQ-016 negative  output  1  out[WIDTH-1].
REQ-017 err  output  1  one-cycle pulse on rejected reserved op code.

Function
REQ-018 Block SHALL compute the op bit-serially through one internal 1-bit ALU slice, LSB first, one bit per clock.
REQ-019 Slice SHALL implement: ADD sum=a^b^cin, cout=majority(a,b,cin); SUB same with b inverted; AND/OR/NOR/XOR bitwise, cout=0.
REQ-020 States SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE, start=1, control in 2..7: latch A, B, control; bit counter=0; carry register=1 for SUB else 0; go RUN.
REQ-022 IDLE, start=1, control in 0..1: stay IDLE, assert err for exactly that next cycle, latch nothing.
REQ-023 RUN: each cycle process bit[counter], write result bit into out[counter], carry register <= slice cout, counter+1.
REQ-024 RUN, counter==WIDTH-1: after processing MSB, go DONE; total latency start-accept edge to out_valid = WIDTH+1 rising edges (33 for WIDTH=32).
REQ-025 Before MSB slice, carry register value SHALL be saved; overflow = saved carry XOR MSB cout for ADD/SUB.
REQ-026 RUN, abort=1: go IDLE that edge, no out_valid, out/flags unchanged from prior DONE values are NOT guaranteed; abort takes priority over MSB completion.
REQ-027 DONE: out, carryout, overflow, zero, negative SHALL be stable until leaving DONE.
REQ-028 DONE, ack=1: go IDLE; start on the same cycle SHALL be ignored (accepted earliest next cycle).
REQ-029 start in RUN or DONE SHALL be ignored; A/B/control changes after acceptance SHALL NOT affect result.
REQ-030 zero and negative SHALL be derived from the final out word; carryout/overflow SHALL be 0 for logic ops.
REQ-031 Counter width SHALL be ceil(log2(WIDTH)); no wrap beyond WIDTH-1.

Reset
REQ-032 reset low SHALL immediately force IDLE, busy=0, out_valid=0, err=0, out=0, carryout=0, overflow=0, zero=0, negative=0, counter=0, carry=0, independent of clock.
REQ-033 reset asserted mid-RUN or in DONE SHALL discard the operation; first start after release SHALL be accepted normally.

Verification
REQ-034 ADD A=0x7FFFFFFF, B=1 -> after 33 edges out=0x80000000, overflow=1, carryout=0, negative=1, zero=0.
REQ-035 SUB A=5, B=5 -> out=0, zero=1, carryout=1, overflow=0; SUB A=0, B=1 -> out=0xFFFFFFFF, carryout=0, negative=1.
REQ-036 XOR A=0xF0F0F0F0, B=0xFFFF0000, then NOR A=0, B=0 -> 0x0F0FF0F0 then 0xFFFFFFFF, carryout=overflow=0 both.
REQ-037 control=1 with start -> err pulse one cycle, busy stays 0, next start control=2 accepted.
REQ-038 abort at RUN cycle 10 -> IDLE next edge, out_valid never asserted; reset low at RUN cycle 20 -> all outputs 0 asynchronously.
REQ-039 Hold ack=0 10 cycles in DONE with start=1 -> outputs stable, no restart; ack=1 -> IDLE.
